// File: rtl/dcache_nway_ctrl_if.sv
// Signal bundle between the MEM-stage data cache, the CPU pipeline and line-wide memory.
interface dcache_nway_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32,
  parameter int LINE_W = 256
);
  logic [ADDR_W-1:0] cpu_addr_i;
  logic [WORD_W-1:0] cpu_data_i;
  logic              cpu_MemRead_i;
  logic              cpu_MemWrite_i;
  logic [WORD_W-1:0] cpu_data_o;
  logic              cpu_stall_o;
  logic [LINE_W-1:0] mem_data_i;
  logic              mem_ack_i;
  logic [LINE_W-1:0] mem_data_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_enable_o;
  logic              mem_write_o;

  modport slave (
    input  cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i, mem_data_i, mem_ack_i,
    output cpu_data_o, cpu_stall_o, mem_data_o, mem_addr_o, mem_enable_o, mem_write_o
  );

  modport master (
    output cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i, mem_data_i, mem_ack_i,
    input  cpu_data_o, cpu_stall_o, mem_data_o, mem_addr_o, mem_enable_o, mem_write_o
  );
endinterface

// File: rtl/dcache_nway_ctrl.sv
// N-way set-associative write-back / write-allocate data cache controller with per-set
// age-counter LRU; stalls the pipeline while a line is written back and refilled.
module dcache_nway_ctrl #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32,
  parameter int LINE_W = 256,
  parameter int SETS   = 16,
  parameter int WAYS   = 2
) (
  input logic               clk_i,
  input logic               rst_i,
  dcache_nway_ctrl_if.slave bus
);
  localparam int OFF    = $clog2(LINE_W / 8);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - OFF - IDX_W;
  localparam int WPL    = LINE_W / WORD_W;
  localparam int WSEL_W = $clog2(WPL);
  localparam int BYTE_W = $clog2(WORD_W / 8);
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [WAY_W-1:0] AGE_MAX = WAY_W'(WAYS - 1);

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, REFILL} state_e;
  typedef logic [WPL-1:0][WORD_W-1:0] line_t;

  state_e           state_q, state_d;
  logic [WAY_W-1:0] victim_q, victim_d;
  line_t            refill_q;

  line_t            data_q  [WAYS][SETS];
  logic [TAG_W-1:0] tag_q   [WAYS][SETS];
  logic             valid_q [WAYS][SETS];
  logic             dirty_q [WAYS][SETS];
  logic [WAY_W-1:0] age_q   [WAYS][SETS];

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  req_tag;
  logic [WSEL_W-1:0] wsel;
  logic              req, is_store, hit, idle_hit, pick_found;
  logic [WAY_W-1:0]  hit_way, pick_way;
  logic [ADDR_W-1:0] wb_addr, al_addr;
  logic              unused_bits;

  assign idx         = bus.cpu_addr_i[OFF+IDX_W-1:OFF];
  assign req_tag     = bus.cpu_addr_i[ADDR_W-1:OFF+IDX_W];
  assign wsel        = bus.cpu_addr_i[OFF-1:BYTE_W];
  assign unused_bits = ^bus.cpu_addr_i[BYTE_W-1:0];
  assign req         = bus.cpu_MemRead_i | bus.cpu_MemWrite_i;
  assign is_store    = bus.cpu_MemWrite_i;
  assign idle_hit    = (state_q == IDLE) && req && hit;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && valid_q[w][idx] && (tag_q[w][idx] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Victim: first invalid way, otherwise the way whose age has reached the maximum.
  always_comb begin
    pick_found = 1'b0;
    pick_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!pick_found && !valid_q[w][idx]) begin
        pick_found = 1'b1;
        pick_way   = WAY_W'(w);
      end
    end
    for (int w = 0; w < WAYS; w++) begin
      if (!pick_found && (age_q[w][idx] == AGE_MAX)) begin
        pick_found = 1'b1;
        pick_way   = WAY_W'(w);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    victim_d = victim_q;
    unique case (state_q)
      IDLE: begin
        if (req && !hit) begin
          victim_d = pick_way;
          state_d  = (valid_q[pick_way][idx] && dirty_q[pick_way][idx]) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: if (bus.mem_ack_i) state_d = ALLOCATE;
      ALLOCATE:  if (bus.mem_ack_i) state_d = REFILL;
      REFILL:    state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      victim_q <= '0;
      for (int w = 0; w < WAYS; w++) begin
        for (int s = 0; s < SETS; s++) begin
          valid_q[w][s] <= 1'b0;
          dirty_q[w][s] <= 1'b0;
          age_q[w][s]   <= '0;
        end
      end
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      if (idle_hit) begin
        for (int w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == hit_way)
            age_q[w][idx] <= '0;
          else if (age_q[w][idx] < age_q[hit_way][idx])
            age_q[w][idx] <= age_q[w][idx] + 1'b1;
        end
        if (is_store) dirty_q[hit_way][idx] <= 1'b1;
      end
      // A fresh line starts oldest so the hit that follows ages every other valid way.
      if (state_q == REFILL) begin
        valid_q[victim_q][idx] <= 1'b1;
        dirty_q[victim_q][idx] <= 1'b0;
        age_q[victim_q][idx]   <= AGE_MAX;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if ((state_q == ALLOCATE) && bus.mem_ack_i) refill_q <= bus.mem_data_i;
    if (state_q == REFILL) begin
      data_q[victim_q][idx] <= refill_q;
      tag_q[victim_q][idx]  <= req_tag;
    end
    if (idle_hit && is_store) data_q[hit_way][idx][wsel] <= bus.cpu_data_i;
  end

  assign wb_addr = {tag_q[victim_q][idx], idx, {OFF{1'b0}}};
  assign al_addr = {req_tag, idx, {OFF{1'b0}}};

  assign bus.cpu_stall_o  = (state_q != IDLE) || (req && !hit);
  assign bus.cpu_data_o   = idle_hit ? data_q[hit_way][idx][wsel] : '0;
  assign bus.mem_enable_o = (state_q == WRITEBACK) || (state_q == ALLOCATE);
  assign bus.mem_write_o  = (state_q == WRITEBACK);
  assign bus.mem_addr_o   = (state_q == WRITEBACK) ? wb_addr :
                            (state_q == ALLOCATE)  ? al_addr : '0;
  assign bus.mem_data_o   = (state_q == WRITEBACK) ? data_q[victim_q][idx] : '0;
endmodule

// File: tb/tb_dcache_nway_ctrl.sv
// Directed and randomized bench for dcache_nway_ctrl with a line-level LRU reference model.
module tb_dcache_nway_ctrl;
  typedef logic [255:0] line_t;
  localparam int MWAYS = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dcache_nway_ctrl_if #(.ADDR_W(32), .WORD_W(32), .LINE_W(256)) bus ();

  dcache_nway_ctrl #(.ADDR_W(32), .WORD_W(32), .LINE_W(256), .SETS(16), .WAYS(MWAYS)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  line_t           envmem [logic [31:0]];
  line_t           refmem [logic [31:0]];
  line_t           mline  [logic [31:0]];
  bit              mdirty [logic [31:0]];
  longint unsigned mlast  [logic [31:0]];
  longint unsigned stamp = 0;

  logic        ev_w [4];
  logic [31:0] ev_a [4];
  line_t       ev_d [4];
  int          last_nev;
  int          last_stall;
  logic [31:0] last_rdata;

  function automatic line_t line_init(logic [31:0] la);
    line_t l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = la ^ (32'h9E37_79B9 * 32'(w + 1));
    if (la == 32'h40) l[31:0] = 32'h1234_5678;
    return l;
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    mline.delete();
    mdirty.delete();
    mlast.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.cpu_MemRead_i  = 1'b0;
    bus.cpu_MemWrite_i = 1'b0;
    bus.mem_ack_i      = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic run(input bit wr, input logic [31:0] addr, input logic [31:0] wdata, input int lat);
    logic [31:0] la, vla, exp_rd;
    logic [3:0]  set;
    int          wsel, nres, exp_stall, exp_nev, nev, en_cnt, stalls, cyc;
    bit          hit, wb, unstable, gap_watch, gap_err;
    longint unsigned oldest;
    line_t       vline, line;

    la = addr & 32'hFFFF_FFE0;
    set = addr[8:5];
    wsel = int'(addr[4:2]);
    hit = mline.exists(la);
    wb = 1'b0; nres = 0; vla = '0; vline = '0; oldest = 0;
    if (!hit) begin
      foreach (mline[k]) begin
        if (k[8:5] == set) begin
          nres++;
          if (nres == 1 || mlast[k] < oldest) begin
            oldest = mlast[k];
            vla = k;
          end
        end
      end
      if (nres == MWAYS) begin
        if (mdirty[vla]) begin
          wb = 1'b1;
          vline = mline[vla];
          refmem[vla] = vline;
        end
        mline.delete(vla);
        mdirty.delete(vla);
        mlast.delete(vla);
      end
      mline[la] = refmem.exists(la) ? refmem[la] : line_init(la);
      mdirty[la] = 1'b0;
    end
    stamp++;
    mlast[la] = stamp;
    if (wr) begin
      line = mline[la];
      line[wsel*32 +: 32] = wdata;
      mline[la] = line;
      mdirty[la] = 1'b1;
    end
    line = mline[la];
    exp_rd = line[wsel*32 +: 32];
    exp_stall = hit ? 0 : (wb ? 2*lat + 2 : lat + 2);
    exp_nev = hit ? 0 : (wb ? 2 : 1);

    for (int i = 0; i < 4; i++) begin
      ev_w[i] = 1'b0; ev_a[i] = '0; ev_d[i] = '0;
    end
    @(negedge clk);
    bus.cpu_addr_i     = addr;
    bus.cpu_data_i     = wdata;
    bus.cpu_MemWrite_i = wr;
    bus.cpu_MemRead_i  = !wr || ($urandom_range(0, 1) == 1);
    nev = 0; en_cnt = 0; stalls = 0; cyc = 0;
    unstable = 1'b0; gap_watch = 1'b0; gap_err = 1'b0;
    #1;
    while (bus.cpu_stall_o && cyc < 100) begin
      stalls++;
      if (gap_watch && bus.mem_enable_o) gap_err = 1'b1;
      gap_watch = 1'b0;
      if (bus.mem_enable_o && nev < 4) begin
        if (en_cnt == 0) begin
          ev_w[nev] = bus.mem_write_o;
          ev_a[nev] = bus.mem_addr_o;
          ev_d[nev] = bus.mem_data_o;
        end else if (bus.mem_addr_o !== ev_a[nev] || bus.mem_write_o !== ev_w[nev] ||
                     bus.mem_data_o !== ev_d[nev]) begin
          unstable = 1'b1;
        end
        en_cnt++;
        if (en_cnt >= lat) begin
          bus.mem_ack_i = 1'b1;
          if (ev_w[nev]) envmem[ev_a[nev]] = bus.mem_data_o;
          else begin
            bus.mem_data_i = envmem.exists(ev_a[nev]) ? envmem[ev_a[nev]] : line_init(ev_a[nev]);
            gap_watch = 1'b1;
          end
          nev++;
          en_cnt = 0;
        end
      end
      @(negedge clk);
      bus.mem_ack_i = 1'b0;
      #1;
      cyc++;
    end
    check("no_timeout", 256'(cyc >= 100), 256'(0));
    last_nev = nev;
    last_stall = stalls;
    last_rdata = bus.cpu_data_o;
    check("stall_cycles", 256'(stalls), 256'(exp_stall));
    check("mem_requests", 256'(nev), 256'(exp_nev));
    check("mem_stable", 256'(unstable), 256'(0));
    check("gap_after_refill", 256'(gap_err), 256'(0));
    if (wb) begin
      check("wb_write", 256'(ev_w[0]), 256'(1));
      check("wb_addr", 256'(ev_a[0]), 256'(vla));
      check("wb_data", ev_d[0], vline);
      check("alloc_write", 256'(ev_w[1]), 256'(0));
      check("alloc_addr", 256'(ev_a[1]), 256'(la));
    end else if (!hit) begin
      check("alloc_write", 256'(ev_w[0]), 256'(0));
      check("alloc_addr", 256'(ev_a[0]), 256'(la));
    end
    if (!wr) check("load_data", 256'(bus.cpu_data_o), 256'(exp_rd));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          s1;
    logic [31:0] d1;
    logic [31:0] ra;
    bus.cpu_addr_i = '0; bus.cpu_data_i = '0;
    bus.cpu_MemRead_i = 1'b0; bus.cpu_MemWrite_i = 1'b0;
    bus.mem_data_i = '0; bus.mem_ack_i = 1'b0;

    do_reset();
    #1;
    check("rst_stall", 256'(bus.cpu_stall_o), 256'(0));
    check("rst_mem_enable", 256'(bus.mem_enable_o), 256'(0));
    check("rst_mem_write", 256'(bus.mem_write_o), 256'(0));
    check("rst_mem_addr", 256'(bus.mem_addr_o), 256'(0));
    check("rst_mem_data", bus.mem_data_o, 256'(0));
    check("rst_cpu_data", 256'(bus.cpu_data_o), 256'(0));

    run(1'b0, 32'h040, 32'h0, 3);
    check("first_refill_addr", 256'(ev_a[0]), 256'(32'h040));
    check("first_load_data", 256'(last_rdata), 256'(32'h1234_5678));
    check("first_stall_len", 256'(last_stall), 256'(5));
    check("first_no_wb", 256'(last_nev), 256'(1));

    run(1'b1, 32'h044, 32'hDEAD_BEEF, 2);
    check("store_hit_stall", 256'(last_stall), 256'(0));
    run(1'b0, 32'h044, 32'h0, 2);
    check("load_after_store", 256'(last_rdata), 256'(32'hDEAD_BEEF));
    check("hit_no_mem", 256'(last_nev), 256'(0));

    run(1'b0, 32'h040, 32'h0, 2);
    run(1'b0, 32'h240, 32'h0, 2);
    run(1'b0, 32'h040, 32'h0, 2);
    run(1'b0, 32'h440, 32'h0, 2);
    check("lru_refill_addr", 256'(ev_a[0]), 256'(32'h440));
    check("lru_clean_victim", 256'(last_nev), 256'(1));
    run(1'b0, 32'h040, 32'h0, 2);
    check("lru_survivor_hits", 256'(last_stall), 256'(0));

    run(1'b1, 32'h248, 32'hCAFE_F00D, 2);
    run(1'b0, 32'h040, 32'h0, 2);
    run(1'b0, 32'h440, 32'h0, 2);
    check("evict_wb_first", 256'(ev_w[0]), 256'(1));
    check("evict_wb_addr", 256'(ev_a[0]), 256'(32'h240));
    check("evict_wb_word2", 256'(ev_d[0][95:64]), 256'(32'hCAFE_F00D));
    check("evict_alloc_addr", 256'(ev_a[1]), 256'(32'h440));

    @(negedge clk);
    bus.cpu_addr_i = 32'h060; bus.cpu_MemRead_i = 1'b1; bus.cpu_MemWrite_i = 1'b0;
    #1;
    check("rstmid_miss_stall", 256'(bus.cpu_stall_o), 256'(1));
    @(negedge clk); #1;
    check("rstmid_alloc_en", 256'(bus.mem_enable_o), 256'(1));
    check("rstmid_alloc_rd", 256'(bus.mem_write_o), 256'(0));
    check("rstmid_alloc_addr", 256'(bus.mem_addr_o), 256'(32'h060));
    @(negedge clk);
    rst = 1'b1; bus.cpu_MemRead_i = 1'b0;
    @(negedge clk);
    rst = 1'b0; bus.mem_ack_i = 1'b1; bus.mem_data_i = '1;
    #1;
    check("rstmid_en_off", 256'(bus.mem_enable_o), 256'(0));
    check("rstmid_stall_off", 256'(bus.cpu_stall_o), 256'(0));
    @(negedge clk);
    bus.mem_ack_i = 1'b0;
    #1;
    check("rstmid_late_ack_ignored", 256'(bus.mem_enable_o), 256'(0));
    model_clear();
    run(1'b0, 32'h040, 32'h0, 2);
    check("rstmid_reload_misses", 256'(last_stall), 256'(4));

    do_reset();
    run(1'b0, 32'h0A4, 32'h0, 1);
    s1 = last_stall; d1 = last_rdata;
    do_reset();
    run(1'b0, 32'h0A4, 32'h0, 10);
    check("lat_same_data", 256'(last_rdata), 256'(d1));
    check("lat_stall_delta", 256'(last_stall - s1), 256'(9));

    for (int i = 0; i < 200; i++) begin
      ra = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 3) << 5) |
           ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      run($urandom_range(0, 1) == 1, ra, $urandom, $urandom_range(1, 4));
    end

    @(negedge clk);
    bus.cpu_MemRead_i = 1'b0; bus.cpu_MemWrite_i = 1'b0;
    #1;
    check("idle_no_stall", 256'(bus.cpu_stall_o), 256'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
